seven_seg_digit_driver: RTL and testbench
=========================================

Name: seven_seg_digit_driver

Overview:
Cathode-side companion to the four-digit anode scanner. It holds a 16-bit hex value and per-digit decimal points, and generates its own scan tick from a prescaler. It walks a one-hot active-low anode ring (leftmost digit first) and drives the matching active-low segment pattern in the same cycle. New values are double-buffered and committed only at frame boundaries, so a digit never shows a half-updated value. It sits between the datapath and the board's anode/cathode pins.

Parameters:
DIV_MAX, 99999, scan tick asserted when prescaler equals DIV_MAX; one digit period = DIV_MAX+1 clk cycles
DIV_WIDTH, 17, prescaler width; must hold DIV_MAX

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe; capture value_in/dp_in into pending buffer
value_in  input  16  hex digits; [15:12] leftmost (anode[0]) ... [3:0] rightmost (anode[3])
dp_in  input  4  decimal-point request per digit, bit k -> anode[k], active-high
enable  input  1  0 = all digits dark; scanning continues
pending  output  1  high while a loaded value awaits commit
anode  output  4  active-low digit select, one-hot-low
seg  output  7  active-low cathodes {g,f,e,d,c,b,a}
dp  output  1  active-low decimal point

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - prescaler=0, digit index=0.
  - active value=16'h0000, active dp=4'b0000.
  - pending buffer cleared, pending=0.
  - anode=4'b1110, seg=7'h40, dp=1.
- Reset mid-frame: takes effect on the next edge and discards any pending load.
- Prescaler:
  - Increments every cycle.
  - When it equals DIV_MAX, it wraps to 0 and asserts the internal tick for that cycle.
- Digit index:
  - Advances 0->1->2->3->0 on each tick.
  - All outputs are registered. Index, anode, seg and dp update together on the edge ending the tick cycle, with no skew between anode and cathodes.
- Anode mapping: index k drives anode bit k low and all other bits high (4'b1110, 4'b1101, 4'b1011, 4'b0111).
- Segment encoding, hex 0..F:
  - 0..7: 40,79,24,30,19,12,02,78.
  - 8..F: 00,10,08,03,46,21,06,0E.
- dp output is ~(active dp bit of the displayed digit).
- Load:
  - When load=1, value_in/dp_in go into the pending buffer and pending=1 on the next edge.
  - Back-to-back loads overwrite the buffer; the last one wins.
- Commit:
  - Occurs on a tick where the index wraps 3->0.
  - If pending=1, the active registers take the buffer contents at that edge and pending clears.
  - Digit 0 of the new frame shows the new value on that same edge.
- Load coinciding with commit:
  - The commit uses the buffer contents from before the load.
  - The new load is captured into the buffer, and pending stays 1 for the next frame.
- enable=0:
  - anode=4'b1111 on the next edge; seg/dp are don't-care but must still be driven.
  - Prescaler, index, load and commit all keep operating.
- Re-enable: anode resumes on the next edge with the current index, without waiting for a tick.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Any digit left of the most significant nonzero nibble of the active value is blanked: its anode stays 1 during its slot.
  - The rightmost digit (index 3) is never blanked, so 16'h0000 shows a single "0" in slot 3.
  - dp_in does not prevent blanking.
- Undefined: all four digits are always lit, including leading zeros.

Test Plan:
- DIV_MAX=3, release reset -> anode=1110, seg=7'h40, dp=1. Anode steps 1101, 1011, 0111, 1110 every 4 cycles, changing exactly 1 cycle after prescaler==3.
- Load value_in=16'h12AF, dp_in=4'b0100 mid-frame -> pending=1 next cycle. Slots keep showing 0 until the 3->0 wrap. Then seg=79,24,08,0E; dp low only in slot 2; pending=0.
- Load 16'h1111 then 16'h2222 in the same frame -> only 2222 is displayed after the commit (seg=24 in all slots).
- Assert load=16'h3333 on the commit tick while pending already holds 16'h4444 -> the frame shows 4444 (seg=19), pending stays 1, and the next frame shows 3333 (seg=30).
- enable=0 for 10 cycles -> anode=1111 throughout while the index keeps advancing. On re-enable, the slot matches the free-running index.
- LEADING_ZERO_BLANK_EN, value 16'h0050 -> slots 0 and 1 dark (anode=1111 during them), slot 2 seg=12, slot 3 seg=40. With value 16'h0000 only slot 3 lights, showing seg=40.

Source files
------------

// File: rtl/seven_seg_digit_driver.sv
// Four-digit multiplexed seven-segment driver: prescaled scan, double-buffered hex value and DPs.
// Optional LEADING_ZERO_BLANK_EN darkens digits left of the most significant nonzero nibble.
module seven_seg_digit_driver #(
    parameter int unsigned DIV_MAX   = 99999,
    parameter int unsigned DIV_WIDTH = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        enable,
    output logic        pending,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [DIV_WIDTH-1:0] DivMax = DIV_WIDTH'(DIV_MAX);

    logic [DIV_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [1:0]           idx_q, idx_d;
    logic [15:0]          value_q, value_d, buf_value_q, buf_value_d;
    logic [3:0]           dp_act_q, dp_act_d, buf_dp_q, buf_dp_d;
    logic                 pend_q, pend_d;
    logic [3:0]           anode_q, anode_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic                 tick, commit, blank;
    logic [3:0]           nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h7F;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick        = (prescaler_q == DivMax);
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        // Commit only at the frame wrap so a frame never mixes old and new digits.
        commit      = tick && (idx_q == 2'd3) && pend_q;
        value_d     = commit ? buf_value_q : value_q;
        dp_act_d    = commit ? buf_dp_q : dp_act_q;
        buf_value_d = load ? value_in : buf_value_q;
        buf_dp_d    = load ? dp_in : buf_dp_q;
        pend_d      = load ? 1'b1 : (commit ? 1'b0 : pend_q);
    end

    // Outputs are decoded from next-state index/value so anode and cathodes move together.
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        case (idx_d)
            2'd0: nibble = value_d[15:12];
            2'd1: nibble = value_d[11:8];
            2'd2: nibble = value_d[7:4];
            2'd3: nibble = value_d[3:0];
            default: nibble = 4'h0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd0: blank = (value_d[15:12] == 4'h0);
            2'd1: blank = (value_d[15:8] == 8'h00);
            2'd2: blank = (value_d[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
`endif
        anode_d = (enable && !blank) ? ~(4'b0001 << idx_d) : 4'b1111;
        seg_d   = hex_to_seg(nibble);
        dp_d    = ~dp_act_d[idx_d];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q <= '0;
            idx_q       <= 2'd0;
            value_q     <= 16'h0000;
            dp_act_q    <= 4'b0000;
            buf_value_q <= 16'h0000;
            buf_dp_q    <= 4'b0000;
            pend_q      <= 1'b0;
            anode_q     <= 4'b1110;
            seg_q       <= 7'h40;
            dp_q        <= 1'b1;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            value_q     <= value_d;
            dp_act_q    <= dp_act_d;
            buf_value_q <= buf_value_d;
            buf_dp_q    <= buf_dp_d;
            pend_q      <= pend_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign pending = pend_q;
    assign anode   = anode_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed bench for seven_seg_digit_driver with DIV_MAX=3 (16-cycle frame).
// Honours LEADING_ZERO_BLANK_EN when defined.
module tb_seven_seg_digit_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        enable = 1'b1;
    logic        pending;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_fail   = 0;
    int pos      = 0;  // cycles since frame start, mod 16

    seven_seg_digit_driver #(.DIV_MAX(3), .DIV_WIDTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value_in (value_in),
        .dp_in    (dp_in),
        .enable   (enable),
        .pending  (pending),
        .anode    (anode),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] anode_exp(input int slot, input logic [15:0] v);
        logic [3:0] a;
        a = 4'b1111;
        a[slot] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if ((slot == 0 && v[15:12] == 4'h0) || (slot == 1 && v[15:8] == 8'h00) ||
            (slot == 2 && v[15:4] == 12'h000))
            a = 4'b1111;
`else
        if (v == 16'hFFFF && slot > 3) a = 4'b1111;
`endif
        return a;
    endfunction

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pos = (pos + 1) % 16;
        end
    endtask

    task automatic goto_pos(input int p);
        adv(1);
        while (pos != p) adv(1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value_in = v; dp_in = d;
        adv(1);
        load = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        adv(2);
        reset = 1'b0;
        pos = 0;
        n_checks++;
        if (anode !== 4'b1110) begin n_fail++; $display("FAIL reset_anode got %b want 1110", anode); end
        n_checks++;
        if (seg !== 7'h40) begin n_fail++; $display("FAIL reset_seg got %h want 40", seg); end
        n_checks++;
        if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got %b want 1", dp); end
        n_checks++;
        if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
    endtask

    task automatic test_scan;
        for (int i = 0; i < 16; i++) begin
            adv(1);
            n_checks++;
            if (anode !== anode_exp(pos / 4, 16'h0000)) begin
                n_fail++;
                $display("FAIL scan_anode pos %0d got %b want %b", pos, anode, anode_exp(pos / 4, 16'h0000));
            end
            n_checks++;
            if (seg !== 7'h40) begin n_fail++; $display("FAIL scan_seg pos %0d got %h want 40", pos, seg); end
        end
    endtask

    task automatic test_load;
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h79; exp_seg[1] = 7'h24; exp_seg[2] = 7'h08; exp_seg[3] = 7'h0E;
        goto_pos(5);
        do_load(16'h12AF, 4'b0100);
        n_checks++;
        if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending got %b want 1", pending); end
        goto_pos(15);
        n_checks++;
        if (seg !== 7'h40 || anode !== 4'b0111) begin
            n_fail++; $display("FAIL load_hold got seg %h anode %b want 40 0111", seg, anode);
        end
        for (int s = 0; s < 4; s++) begin
            goto_pos(s * 4);
            n_checks++;
            if (seg !== exp_seg[s] || anode !== anode_exp(s, 16'h12AF) || dp !== (s != 2)) begin
                n_fail++;
                $display("FAIL load_commit slot %0d got seg %h anode %b dp %b want %h %b %b",
                         s, seg, anode, dp, exp_seg[s], anode_exp(s, 16'h12AF), s != 2);
            end
        end
        n_checks++;
        if (pending !== 1'b0) begin n_fail++; $display("FAIL load_pending_clear got %b want 0", pending); end
    endtask

    task automatic test_back_to_back;
        goto_pos(3);
        do_load(16'h1111, 4'b0000);
        do_load(16'h2222, 4'b0000);
        for (int s = 0; s < 4; s++) begin
            goto_pos(s * 4);
            n_checks++;
            if (seg !== 7'h24 || dp !== 1'b1) begin
                n_fail++; $display("FAIL b2b slot %0d got seg %h dp %b want 24 1", s, seg, dp);
            end
        end
    endtask

    task automatic test_coincide;
        goto_pos(2);
        do_load(16'h4444, 4'b0000);
        goto_pos(15);
        do_load(16'h3333, 4'b0000);
        n_checks++;
        if (seg !== 7'h19 || pending !== 1'b1) begin
            n_fail++; $display("FAIL coincide_frame1 got seg %h pending %b want 19 1", seg, pending);
        end
        goto_pos(12);
        n_checks++;
        if (seg !== 7'h19) begin n_fail++; $display("FAIL coincide_slot3 got %h want 19", seg); end
        goto_pos(0);
        n_checks++;
        if (seg !== 7'h30 || pending !== 1'b0) begin
            n_fail++; $display("FAIL coincide_frame2 got seg %h pending %b want 30 0", seg, pending);
        end
    endtask

    task automatic test_enable;
        goto_pos(6);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adv(1);
            n_checks++;
            if (anode !== 4'b1111) begin n_fail++; $display("FAIL disable_anode pos %0d got %b want 1111", pos, anode); end
        end
        enable = 1'b1;
        adv(1);
        n_checks++;
        if (anode !== anode_exp(pos / 4, 16'h3333) || seg !== 7'h30) begin
            n_fail++;
            $display("FAIL reenable pos %0d got anode %b seg %h want %b 30", pos, anode, seg, anode_exp(pos / 4, 16'h3333));
        end
    endtask

    task automatic test_blank;
        logic [3:0] a_exp [4];
        logic [6:0] s_exp [4];
`ifdef LEADING_ZERO_BLANK_EN
        a_exp[0] = 4'b1111; a_exp[1] = 4'b1111; a_exp[2] = 4'b1011; a_exp[3] = 4'b0111;
`else
        a_exp[0] = 4'b1110; a_exp[1] = 4'b1101; a_exp[2] = 4'b1011; a_exp[3] = 4'b0111;
`endif
        s_exp[0] = 7'h40; s_exp[1] = 7'h40; s_exp[2] = 7'h12; s_exp[3] = 7'h40;
        do_load(16'h0050, 4'b0011);
        for (int s = 0; s < 4; s++) begin
            goto_pos(s * 4);
            n_checks++;
            if (anode !== a_exp[s] || (a_exp[s] != 4'b1111 && seg !== s_exp[s])) begin
                n_fail++;
                $display("FAIL blank_0050 slot %0d got anode %b seg %h want %b %h", s, anode, seg, a_exp[s], s_exp[s]);
            end
        end
        do_load(16'h0000, 4'b0000);
        for (int s = 0; s < 4; s++) begin
            goto_pos(s * 4);
            n_checks++;
            if (anode !== anode_exp(s, 16'h0000) || seg !== 7'h40) begin
                n_fail++;
                $display("FAIL blank_0000 slot %0d got anode %b seg %h want %b 40", s, anode, seg, anode_exp(s, 16'h0000));
            end
        end
    endtask

    task automatic test_reset_mid;
        do_load(16'hABCD, 4'b1111);
        reset = 1'b1;
        adv(1);
        reset = 1'b0;
        pos = 0;
        n_checks++;
        if (pending !== 1'b0 || anode !== 4'b1110 || seg !== 7'h40 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got pending %b anode %b seg %h dp %b want 0 1110 40 1", pending, anode, seg, dp);
        end
        adv(16);
        goto_pos(12);
        n_checks++;
        if (seg !== 7'h40 || pending !== 1'b0 || anode !== 4'b0111) begin
            n_fail++;
            $display("FAIL reset_discard got seg %h pending %b anode %b want 40 0 0111", seg, pending, anode);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_scan();
        test_load();
        test_back_to_back();
        test_coincide();
        test_enable();
        test_blank();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
